// File: rtl/kbd_event_decoder.sv
// kbd_event_decoder: turns the ps2_keyboard scan-code FIFO into decoded key events.
// Handles set-2 F0/E0 prefixes, flags typematic repeats, counts presses.
// Optional macro KBD_ASCII_EN adds a set-2 to ASCII lookup on key_ascii;
// without it key_ascii stays 0x00.
module kbd_event_decoder #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         kb_data,
    input  logic               kb_ready,
    input  logic               kb_overflow,
    output logic               kb_nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_break,
    output logic               key_repeat,
    output logic               key_down,
    output logic [7:0]         key_ascii,
    output logic [COUNT_W-1:0] press_count,
    output logic               ovf_flag
);

    localparam int unsigned CODE_W = 8;
    localparam int unsigned KEY_W  = CODE_W + 1;
    localparam logic [CODE_W-1:0] BRK_PREFIX = 8'hF0;
    localparam logic [CODE_W-1:0] EXT_PREFIX = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               brk_f;
    logic               brk_f_nxt;
    logic               ext_f;
    logic               ext_f_nxt;
    logic [KEY_W-1:0]   held_code;
    logic [KEY_W-1:0]   held_nxt;
    logic               nextdata_n_nxt;
    logic               valid_nxt;
    logic [7:0]         code_nxt;
    logic               ext_nxt;
    logic               break_nxt;
    logic               repeat_nxt;
    logic               down_nxt;
    logic [7:0]         ascii_nxt;
    logic [COUNT_W-1:0] count_nxt;
    logic [KEY_W-1:0]   key_id_c;
    logic [7:0]         ascii_c;

    // Identity of the key in the head byte, qualified by the pending E0 prefix
    assign key_id_c = {ext_f, kb_data};

`ifdef KBD_ASCII_EN
    // Set-2 make code to ASCII; letters map to lowercase
    function automatic logic [7:0] set2_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;
            8'h23: a = 8'h64;  8'h24: a = 8'h65;  8'h2B: a = 8'h66;
            8'h34: a = 8'h67;  8'h33: a = 8'h68;  8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;  8'h15: a = 8'h71;  8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;  8'h2C: a = 8'h74;  8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;
            8'h26: a = 8'h33;  8'h25: a = 8'h34;  8'h2E: a = 8'h35;
            8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Extended keys never carry an ASCII meaning
    assign ascii_c = ext_f ? 8'h00 : set2_ascii(kb_data);
`else
    assign ascii_c = 8'h00;
`endif

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            kb_nextdata_n <= 1'b1;
            key_valid     <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_break     <= 1'b0;
            key_repeat    <= 1'b0;
            key_down      <= 1'b0;
            key_ascii     <= 8'h00;
            press_count   <= '0;
            ovf_flag      <= 1'b0;
            brk_f         <= 1'b0;
            ext_f         <= 1'b0;
            held_code     <= '0;
        end else begin
            state         <= state_nxt;
            kb_nextdata_n <= nextdata_n_nxt;
            key_valid     <= valid_nxt;
            key_code      <= code_nxt;
            key_ext       <= ext_nxt;
            key_break     <= break_nxt;
            key_repeat    <= repeat_nxt;
            key_down      <= down_nxt;
            key_ascii     <= ascii_nxt;
            press_count   <= count_nxt;
            ovf_flag      <= ovf_flag | kb_overflow;
            brk_f         <= brk_f_nxt;
            ext_f         <= ext_f_nxt;
            held_code     <= held_nxt;
        end
    end

    // Next state and next outputs; the head byte is decoded as it is accepted
    // so the pop strobe and the event strobe share the S_POP cycle
    always_comb begin
        state_nxt      = state;
        nextdata_n_nxt = 1'b1;
        valid_nxt      = 1'b0;
        code_nxt       = key_code;
        ext_nxt        = key_ext;
        break_nxt      = key_break;
        repeat_nxt     = key_repeat;
        down_nxt       = key_down;
        ascii_nxt      = key_ascii;
        count_nxt      = press_count;
        brk_f_nxt      = brk_f;
        ext_f_nxt      = ext_f;
        held_nxt       = held_code;

        case (state)
            S_IDLE: begin
                if (kb_ready) begin
                    state_nxt      = S_POP;
                    nextdata_n_nxt = 1'b0;
                    if (kb_data == BRK_PREFIX) begin
                        brk_f_nxt = 1'b1;
                    end else if (kb_data == EXT_PREFIX) begin
                        ext_f_nxt = 1'b1;
                    end else begin
                        valid_nxt  = 1'b1;
                        code_nxt   = kb_data;
                        ext_nxt    = ext_f;
                        break_nxt  = brk_f;
                        ascii_nxt  = ascii_c;
                        repeat_nxt = 1'b0;
                        brk_f_nxt  = 1'b0;
                        ext_f_nxt  = 1'b0;
                        if (!brk_f) begin
                            if (key_down && (key_id_c == held_code)) begin
                                repeat_nxt = 1'b1;
                            end else begin
                                held_nxt  = key_id_c;
                                down_nxt  = 1'b1;
                                count_nxt = press_count + COUNT_W'(1);
                            end
                        end else if (key_id_c == held_code) begin
                            down_nxt = 1'b0;
                        end
                    end
                end
            end
            S_POP: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
